wcdma_ovsf_spreader: RTL and testbench

- Downstream consumer of wcdma_ovsf_generator.
- Takes complex I/Q symbols on an AXI-Stream slave and the OVSF code word and spreading factor from the generator.
- Emits SF chips per symbol on an AXI-Stream master, each chip = symbol × (±1).
- Output feeds the scrambler/pulse-shaping stage; full backpressure, no bubbles between back-to-back symbols.

---
 rtl/wcdma_ovsf_spreader.sv | 145 ++++++++++++++
 tb/tb_wcdma_ovsf_spreader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/wcdma_ovsf_spreader.sv
// OVSF spreader: repeats each complex symbol SF times, multiplying it by the
// +/-1 chips of the code word latched from the generator at symbol accept.
module wcdma_ovsf_spreader #(
    parameter int DATA_W = 16,
    parameter int SF_MAX = 256,
    parameter int SFL_W  = 4
) (
    input  logic                  aclk,
    input  logic                  arst,
    input  logic [SFL_W-1:0]      cfg_sf_log2,
    input  logic [SF_MAX-1:0]     cfg_code,
    input  logic [2*DATA_W-1:0]   s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [2*DATA_W-1:0]   m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [7:0]            m_axis_tuser,
    output logic                  busy
);

    localparam int CNT_W = 8;

    typedef enum logic {
        IDLE,
        SPREAD
    } state_t;

    state_t               state_q, state_d;
    logic                 run_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     sf_m1_q, sf_m1_d;
    logic [CNT_W-1:0]     sf_m1_cfg;
    logic [SFL_W-1:0]     sfl_clamped;
    logic [SF_MAX-1:0]    code_q, code_d;
    logic [2*DATA_W-1:0]  sym_q, sym_d;
    logic [2*DATA_W-1:0]  chip_q, chip_d;
    logic                 last_q, last_d;
    logic                 sym_accept;
    logic                 chip_accept;
    logic                 last_chip;

    // Negating the most negative value would overflow, so it saturates.
    function automatic logic [DATA_W-1:0] neg_sat(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] most_neg;
        most_neg = {1'b1, {(DATA_W-1){1'b0}}};
        if (x == most_neg) begin
            return ~most_neg;
        end
        return ~x + DATA_W'(1);
    endfunction

    function automatic logic [2*DATA_W-1:0] apply_chip(
        input logic [2*DATA_W-1:0] sym,
        input logic                neg
    );
        if (!neg) begin
            return sym;
        end
        return {neg_sat(sym[2*DATA_W-1:DATA_W]), neg_sat(sym[DATA_W-1:0])};
    endfunction

    always_comb begin
        sfl_clamped = cfg_sf_log2;
        if (cfg_sf_log2 < SFL_W'(2)) begin
            sfl_clamped = SFL_W'(2);
        end else if (cfg_sf_log2 > SFL_W'(8)) begin
            sfl_clamped = SFL_W'(8);
        end
        sf_m1_cfg = ~({CNT_W{1'b1}} << sfl_clamped);
    end

    always_comb begin
        last_chip     = (cnt_q == sf_m1_q);
        m_axis_tvalid = (state_q == SPREAD);
        busy          = (state_q == SPREAD);
        s_axis_tready = run_q && ((state_q == IDLE) || (m_axis_tready && last_chip));
        m_axis_tlast  = (state_q == SPREAD) && last_q && last_chip;
        m_axis_tuser  = cnt_q;
        m_axis_tdata  = chip_q;
    end

    always_comb begin
        sym_accept  = s_axis_tvalid && s_axis_tready;
        chip_accept = (state_q == SPREAD) && m_axis_tready;
        state_d     = state_q;
        if (sym_accept) begin
            state_d = SPREAD;
        end else if (chip_accept && last_chip) begin
            state_d = IDLE;
        end
    end

    // A new symbol wins over advancing, which is what removes the bubble.
    always_comb begin
        cnt_d   = cnt_q;
        sf_m1_d = sf_m1_q;
        code_d  = code_q;
        sym_d   = sym_q;
        last_d  = last_q;
        chip_d  = chip_q;
        if (sym_accept) begin
            cnt_d   = '0;
            sf_m1_d = sf_m1_cfg;
            code_d  = cfg_code;
            sym_d   = s_axis_tdata;
            last_d  = s_axis_tlast;
            chip_d  = apply_chip(s_axis_tdata, cfg_code[0]);
        end else if (chip_accept && !last_chip) begin
            cnt_d  = cnt_q + CNT_W'(1);
            chip_d = apply_chip(sym_q, code_q[cnt_d]);
        end
    end

    always_ff @(posedge aclk or negedge arst) begin
        if (!arst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge aclk or negedge arst) begin
        if (!arst) begin
            run_q   <= 1'b0;
            cnt_q   <= '0;
            sf_m1_q <= '0;
            code_q  <= '0;
            sym_q   <= '0;
            last_q  <= 1'b0;
            chip_q  <= '0;
        end else begin
            run_q   <= 1'b1;
            cnt_q   <= cnt_d;
            sf_m1_q <= sf_m1_d;
            code_q  <= code_d;
            sym_q   <= sym_d;
            last_q  <= last_d;
            chip_q  <= chip_d;
        end
    end

endmodule

// File: tb/tb_wcdma_ovsf_spreader.sv
// Directed bench for wcdma_ovsf_spreader: inputs change and outputs are
// checked on the falling edge, with hand-computed chip values.
module tb_wcdma_ovsf_spreader;

    logic          aclk;
    logic          arst;
    logic [3:0]    cfg_sf_log2;
    logic [255:0]  cfg_code;
    logic [31:0]   s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [31:0]   m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [7:0]    m_axis_tuser;
    logic          busy;

    int vectors;
    int miscompares;

    wcdma_ovsf_spreader #(
        .DATA_W(16),
        .SF_MAX(256),
        .SFL_W(4)
    ) dut (
        .aclk(aclk),
        .arst(arst),
        .cfg_sf_log2(cfg_sf_log2),
        .cfg_code(cfg_code),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser),
        .busy(busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [31:0] pk(input int q, input int i);
        return {q[15:0], i[15:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] sfl, input logic [255:0] code,
                                 input logic [31:0] data, input logic last, input logic valid);
        cfg_sf_log2   = sfl;
        cfg_code      = code;
        s_axis_tdata  = data;
        s_axis_tlast  = last;
        s_axis_tvalid = valid;
    endtask

    task automatic checkChip(input string tag, input int idx, input logic [31:0] data,
                             input logic last, input logic rdy);
        checkOutput({tag, "_tvalid"}, m_axis_tvalid, 1'b1);
        checkOutput({tag, "_tuser"}, m_axis_tuser, idx);
        checkOutput({tag, "_tdata"}, m_axis_tdata, data);
        checkOutput({tag, "_tlast"}, m_axis_tlast, last);
        checkOutput({tag, "_sready"}, s_axis_tready, rdy);
    endtask

    initial begin
        logic [31:0] pos;
        logic [31:0] neg;
        logic [31:0] posB;
        logic [31:0] negB;
        logic [255:0] code;

        vectors       = 0;
        miscompares   = 0;
        arst          = 1'b0;
        m_axis_tready = 1'b1;
        applyStimulus(4'd2, '0, '0, 1'b0, 1'b0);

        // Reset values
        @(negedge aclk);
        checkOutput("rst_tvalid", m_axis_tvalid, 1'b0);
        checkOutput("rst_tdata", m_axis_tdata, 32'h0);
        checkOutput("rst_tuser", m_axis_tuser, 8'h0);
        checkOutput("rst_tlast", m_axis_tlast, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_sready", s_axis_tready, 1'b0);
        arst = 1'b1;
        #1 checkOutput("rel_sready", s_axis_tready, 1'b0);
        @(negedge aclk);
        checkOutput("run_sready", s_axis_tready, 1'b1);

        // SF=4, code 1010, I=100 Q=-50
        applyStimulus(4'd2, 256'b1010, pk(-50, 100), 1'b0, 1'b1);
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        checkChip("t1c0", 0, pk(-50, 100), 1'b0, 1'b0);
        @(negedge aclk);
        checkChip("t1c1", 1, pk(50, -100), 1'b0, 1'b0);
        @(negedge aclk);
        checkChip("t1c2", 2, pk(-50, 100), 1'b0, 1'b0);
        @(negedge aclk);
        checkChip("t1c3", 3, pk(50, -100), 1'b0, 1'b1);
        @(negedge aclk);
        checkOutput("t1_idle_tvalid", m_axis_tvalid, 1'b0);
        checkOutput("t1_idle_busy", busy, 1'b0);

        // Back-to-back symbols, code 0110, no bubble
        pos  = pk(2, 1);
        neg  = pk(-2, -1);
        posB = pk(4, 3);
        negB = pk(-4, -3);
        code = 256'b0110;
        applyStimulus(4'd2, code, pos, 1'b0, 1'b1);
        @(negedge aclk);
        s_axis_tdata = posB;
        for (int k = 0; k < 4; k++) begin
            checkChip("t2a", k, code[k] ? neg : pos, 1'b0, k == 3);
            @(negedge aclk);
        end
        s_axis_tvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkChip("t2b", k, code[k] ? negB : posB, 1'b0, k == 3);
            @(negedge aclk);
        end
        checkOutput("t2_idle_tvalid", m_axis_tvalid, 1'b0);

        // Saturation
        applyStimulus(4'd2, {256{1'b1}}, pk(32767, -32768), 1'b0, 1'b1);
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkChip("t3", k, 32'h8001_7FFF, 1'b0, k == 3);
            @(negedge aclk);
        end

        // Backpressure, SF=8, chip 2 negated, stalled 3 cycles
        pos  = pk(-9, 7);
        neg  = pk(9, -7);
        code = 256'b0000_0100;
        applyStimulus(4'd3, code, pos, 1'b0, 1'b1);
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checkChip("t4", k, code[k] ? neg : pos, 1'b0, k == 7);
            if (k == 2) begin
                m_axis_tready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge aclk);
                    checkChip("t4hold", 2, neg, 1'b0, 1'b0);
                end
                m_axis_tready = 1'b1;
            end
            @(negedge aclk);
        end
        checkOutput("t4_idle_tvalid", m_axis_tvalid, 1'b0);

        // Clamp above: cfg 9 acts as SF=256; mid-symbol cfg change ignored
        pos  = pk(6, 5);
        neg  = pk(-6, -5);
        code = '0;
        code[128] = 1'b1;
        code[255] = 1'b1;
        applyStimulus(4'd9, code, pos, 1'b1, 1'b1);
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        for (int k = 0; k < 256; k++) begin
            if (k == 10) begin
                cfg_sf_log2 = 4'd2;
                cfg_code    = {256{1'b1}};
            end
            checkChip("t5", k, code[k] ? neg : pos, k == 255, k == 255);
            @(negedge aclk);
        end
        checkOutput("t5_idle_tvalid", m_axis_tvalid, 1'b0);

        // Clamp below: cfg 1 acts as SF=4; bit 4 beyond SF is ignored
        code = 256'b1_0001;
        applyStimulus(4'd1, code, pos, 1'b1, 1'b1);
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkChip("t6", k, code[k] ? neg : pos, k == 3, k == 3);
            @(negedge aclk);
        end
        checkOutput("t6_idle_tvalid", m_axis_tvalid, 1'b0);

        // Reset mid-symbol at chip 5 of SF=16
        applyStimulus(4'd4, 256'b10, pk(2, 1), 1'b0, 1'b1);
        @(negedge aclk);
        s_axis_tdata = pk(20, 10);
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
        end
        checkOutput("t7_pre_tuser", m_axis_tuser, 8'd5);
        arst = 1'b0;
        #1;
        checkOutput("t7_rst_tvalid", m_axis_tvalid, 1'b0);
        checkOutput("t7_rst_busy", busy, 1'b0);
        checkOutput("t7_rst_tdata", m_axis_tdata, 32'h0);
        checkOutput("t7_rst_sready", s_axis_tready, 1'b0);
        @(negedge aclk);
        arst = 1'b1;
        #1 checkOutput("t7_rel_sready", s_axis_tready, 1'b0);
        @(negedge aclk);
        checkOutput("t7_run_sready", s_axis_tready, 1'b1);
        checkOutput("t7_run_tvalid", m_axis_tvalid, 1'b0);
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        checkChip("t7c0", 0, pk(20, 10), 1'b0, 1'b0);
        @(negedge aclk);
        checkChip("t7c1", 1, pk(-20, -10), 1'b0, 1'b0);
        for (int k = 0; k < 15; k++) begin
            @(negedge aclk);
        end
        checkOutput("t7_idle_tvalid", m_axis_tvalid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
